// File: rtl/uart_tx.sv
// UART transmitter: accepts a word over valid/ready and serialises it as
// start, LSB-first data, optional parity and stop bits, one bit per OVERSAMPLING clocks.
module uart_tx #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned OVERSAMPLING = 16,
  parameter int unsigned PARITY       = 0
) (
  input  logic                 clk_in,
  input  logic                 n_rst,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 ready_out,
  output logic                 tx,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int unsigned CntW = (OVERSAMPLING * STOP_BITS > 1) ?
                                 $clog2(OVERSAMPLING * STOP_BITS) : 1;
  localparam int unsigned BitW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CntW-1:0] BitLast  = CntW'(OVERSAMPLING - 1);
  localparam logic [CntW-1:0] StopLast = CntW'(OVERSAMPLING * STOP_BITS - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
  // Any PARITY value other than odd/even falls back to no parity bit.
  localparam bit              HasParity = (PARITY == 1) || (PARITY == 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                r_state;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_parity;
  logic [CntW-1:0]       r_clk_cnt;
  logic [BitW-1:0]       r_bit_cnt;
  logic                  r_tx;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_done;

  logic w_accept;
  logic w_parity;
  logic w_bit_end;
  logic w_stop_end;

  assign w_accept   = valid_in && r_ready;
  assign w_parity   = (PARITY == 2) ? ^data_in : ~^data_in;
  assign w_bit_end  = (r_clk_cnt == BitLast);
  assign w_stop_end = (r_clk_cnt == StopLast);

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_tx      <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_state   <= StStart;
            r_shift   <= data_in;
            r_parity  <= w_parity;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        StStart: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_state   <= StData;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == DataLast) begin
              r_bit_cnt <= '0;
              if (HasParity) begin
                r_state <= StParity;
                r_tx    <= r_parity;
              end else begin
                r_state <= StStop;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        StParity: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_state   <= StStop;
            r_tx      <= 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        StStop: begin
          // Ready and done rise together so a held valid_in restarts after a 1-cycle gap.
          if (w_stop_end) begin
            r_clk_cnt <= '0;
            r_state   <= StIdle;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= StIdle;
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          r_tx      <= 1'b1;
          r_ready   <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign ready_out = r_ready;
  assign tx        = r_tx;
  assign busy_out  = r_busy;
  assign done_out  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations share one clock; tx is captured per cycle
// and compared with a frame built bit-by-bit from the framing rules.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int Os = 16;

  typedef logic bitq_t[$];
  typedef struct {
    int         sel;
    logic [7:0] data;
    int         exp_len;
    bit         has_par;
    logic       exp_par;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] valid_r;
  logic [7:0] data_r [4];
  logic [3:0] tx_w, rdy_w, busy_w, done_w;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: PARITY=2, 2: PARITY=1, 3: STOP_BITS=2
  uart_tx u_def (
    .clk_in(clk), .n_rst(rst_n), .valid_in(valid_r[0]), .data_in(data_r[0]),
    .ready_out(rdy_w[0]), .tx(tx_w[0]), .busy_out(busy_w[0]), .done_out(done_w[0])
  );
  uart_tx #(.PARITY(2)) u_even (
    .clk_in(clk), .n_rst(rst_n), .valid_in(valid_r[1]), .data_in(data_r[1]),
    .ready_out(rdy_w[1]), .tx(tx_w[1]), .busy_out(busy_w[1]), .done_out(done_w[1])
  );
  uart_tx #(.PARITY(1)) u_odd (
    .clk_in(clk), .n_rst(rst_n), .valid_in(valid_r[2]), .data_in(data_r[2]),
    .ready_out(rdy_w[2]), .tx(tx_w[2]), .busy_out(busy_w[2]), .done_out(done_w[2])
  );
  uart_tx #(.STOP_BITS(2)) u_stop2 (
    .clk_in(clk), .n_rst(rst_n), .valid_in(valid_r[3]), .data_in(data_r[3]),
    .ready_out(rdy_w[3]), .tx(tx_w[3]), .busy_out(busy_w[3]), .done_out(done_w[3])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: one entry per clock of tx, from the bit sequence of the frame.
  function automatic bitq_t frame_of(input int sel, input logic [7:0] d);
    bitq_t bits;
    bitq_t q;
    int    mode;
    int    stops;
    int    ones;
    mode  = (sel == 1) ? 2 : (sel == 2) ? 1 : 0;
    stops = (sel == 3) ? 2 : 1;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (mode != 0) begin
      ones = $countones(d);
      bits.push_back((mode == 2) ? logic'(ones % 2) : logic'(1 - ones % 2));
    end
    for (int s = 0; s < stops; s++) bits.push_back(1'b1);
    foreach (bits[b]) for (int k = 0; k < Os; k++) q.push_back(bits[b]);
    return q;
  endfunction

  // Receiver model: sample each data bit at the middle of its bit period.
  function automatic logic [7:0] decode(input bitq_t tr, input int base);
    logic [7:0] r;
    int         idx;
    for (int i = 0; i < 8; i++) begin
      idx  = base + Os * (1 + i) + Os / 2;
      r[i] = (idx < tr.size()) ? tr[idx] : 1'bx;
    end
    return r;
  endfunction

  function automatic int trace_diff(input bitq_t a, input bitq_t b);
    int n = 0;
    if (a.size() != b.size()) return -1;
    foreach (a[i]) if (a[i] !== b[i]) n++;
    return n;
  endfunction

  task automatic wait_ready(input int sel);
    int n = 0;
    while (rdy_w[sel] !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", rdy_w[sel], 1);
  endtask

  task automatic run_frame(input int sel, input logic [7:0] d, input int exp_len,
                           output bitq_t tr);
    int low = 0;
    int dn  = 0;
    int bb  = 0;
    tr = {};
    wait_ready(sel);
    valid_r[sel] = 1'b1;
    data_r[sel]  = d;
    @(posedge clk); #1;
    valid_r[sel] = 1'b0;
    data_r[sel]  = ~d;
    while (rdy_w[sel] !== 1'b1 && low < 400) begin
      tr.push_back(tx_w[sel]);
      low++;
      if (done_w[sel] === 1'b1) dn++;
      if (busy_w[sel] !== 1'b1) bb++;
      @(posedge clk); #1;
    end
    check("frame_len", low, exp_len);
    check("tx_trace", trace_diff(tr, frame_of(sel, d)), 0);
    check("done_early", dn, 0);
    check("busy_frame", bb, 0);
    check("frame_end", {rdy_w[sel], done_w[sel], tx_w[sel], busy_w[sel]}, 4'b1110);
    @(posedge clk); #1;
    check("done_clear", done_w[sel], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[9];
    bitq_t      tr;
    bitq_t      ex;
    bitq_t      f2;
    int         dn;
    int         bad;
    logic [7:0] w;

    vecs[0] = '{0, 8'h55, 160, 1'b0, 1'b0};
    vecs[1] = '{1, 8'h07, 176, 1'b1, 1'b1};
    vecs[2] = '{2, 8'h07, 176, 1'b1, 1'b0};
    vecs[3] = '{3, 8'h55, 176, 1'b0, 1'b0};
    vecs[4] = '{1, 8'h00, 176, 1'b1, 1'b0};
    vecs[5] = '{2, 8'h00, 176, 1'b1, 1'b1};
    vecs[6] = '{1, 8'hFF, 176, 1'b1, 1'b0};
    vecs[7] = '{2, 8'h80, 176, 1'b1, 1'b0};
    vecs[8] = '{0, 8'hA3, 160, 1'b0, 1'b0};

    valid_r = '0;
    for (int s = 0; s < 4; s++) data_r[s] = '0;
    rst_n = 1'b0;
    #22;
    for (int s = 0; s < 4; s++)
      check("reset_state", {rdy_w[s], done_w[s], tx_w[s], busy_w[s]}, 4'b1010);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven frames across parameterisations.
    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i].sel, vecs[i].data, vecs[i].exp_len, tr);
      check("vec_data", decode(tr, 0), vecs[i].data);
      if (vecs[i].has_par) check("parity_bit", tr.size() > Os * 9 + Os / 2 ?
                                 32'(tr[Os * 9 + Os / 2]) : 32'hFFFF, vecs[i].exp_par);
    end

    // Back-to-back with valid held: 0xA3 then 0x0F, one idle cycle between.
    wait_ready(0);
    valid_r[0] = 1'b1;
    data_r[0]  = 8'hA3;
    @(posedge clk); #1;
    data_r[0] = 8'h0F;
    tr = {};
    dn = 0;
    for (int i = 0; i < 321; i++) begin
      tr.push_back(tx_w[0]);
      if (done_w[0] === 1'b1) dn++;
      if (i == 161) valid_r[0] = 1'b0;
      @(posedge clk); #1;
    end
    ex = frame_of(0, 8'hA3);
    ex.push_back(1'b1);
    f2 = frame_of(0, 8'h0F);
    foreach (f2[i]) ex.push_back(f2[i]);
    check("b2b_trace", trace_diff(tr, ex), 0);
    check("b2b_done", dn, 1);
    check("b2b_word0", decode(tr, 0), 8'hA3);
    check("b2b_word1", decode(tr, 161), 8'h0F);
    wait_ready(0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (rdy_w[0] !== 1'b1 || tx_w[0] !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    check("b2b_no_third", bad, 0);

    // valid pulsed mid-frame on the two-stop-bit instance must be dropped.
    wait_ready(3);
    valid_r[3] = 1'b1;
    data_r[3]  = 8'h3C;
    @(posedge clk); #1;
    valid_r[3] = 1'b0;
    tr = {};
    for (int i = 0; i < 400 && rdy_w[3] !== 1'b1; i++) begin
      tr.push_back(tx_w[3]);
      if (i == 50) begin
        valid_r[3] = 1'b1;
        data_r[3]  = 8'hFF;
      end
      if (i == 51) valid_r[3] = 1'b0;
      @(posedge clk); #1;
    end
    check("ign_trace", trace_diff(tr, frame_of(3, 8'h3C)), 0);
    check("ign_done", done_w[3], 1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (rdy_w[3] !== 1'b1 || tx_w[3] !== 1'b1 || busy_w[3] !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("ign_no_frame", bad, 0);

    // Reset during data bit 3 abandons the frame without a done pulse.
    wait_ready(0);
    valid_r[0] = 1'b1;
    data_r[0]  = 8'h55;
    @(posedge clk); #1;
    valid_r[0] = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_bit3", tx_w[0], 0);
    rst_n = 1'b0;
    #1;
    check("rst_immediate", {rdy_w[0], done_w[0], tx_w[0], busy_w[0]}, 4'b1010);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    dn  = 0;
    for (int i = 0; i < 200; i++) begin
      if (done_w[0] === 1'b1) dn++;
      if (tx_w[0] !== 1'b1 || rdy_w[0] !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    check("rst_no_done", dn, 0);
    check("rst_idle", bad, 0);
    run_frame(0, 8'h5A, 160, tr);
    check("rst_next_data", decode(tr, 0), 8'h5A);

    // Random words through the receiver model with random idle gaps.
    for (int n = 0; n < 256; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      w = 8'($urandom);
      run_frame(0, w, 160, tr);
      check("loopback", decode(tr, 0), w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
